// File: rtl/multu_hilo_unit.sv
// Sequential radix-2 shift-add unsigned multiplier with the HI/LO register pair.
// Stalls the pipeline when MFHI/MFLO or a second MULTU arrives while a multiply is in flight.
module multu_hilo_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic             mf_req,
  input  logic             mf_sel,
  output logic [WIDTH-1:0] hilo_out,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] step_acc;

  // Add into the upper half with carry, then shift {carry, acc} right by one.
  always_comb begin
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    step_acc = {sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d    = step_acc;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            hi_d    = step_acc[2*WIDTH-1:WIDTH];
            lo_d    = step_acc[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    busy     = (state_q == StRun);
    done     = done_q;
    stall    = busy & (mf_req | start);
    hilo_out = mf_sel ? hi_q : lo_q;
  end

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Directed bench for multu_hilo_unit: expected products are queued at issue and
// popped when done pulses.
module tb_multu_hilo_unit;

  localparam int unsigned W = 32;

  logic         clk, rst, start, flush, mf_req, mf_sel;
  logic [W-1:0] op_a, op_b, hilo_out;
  logic         busy, done, stall;

  int vectors    = 0;
  int miscompares = 0;
  logic [2*W-1:0] sb_q[$];

  multu_hilo_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .flush    (flush),
    .mf_req   (mf_req),
    .mf_sel   (mf_sel),
    .hilo_out (hilo_out),
    .busy     (busy),
    .done     (done),
    .stall    (stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: obs=timeout exp=finish");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pop the next expected product and compare both halves through hilo_out.
  task automatic check_result(input string tag);
    logic [63:0] e;
    chk({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      mf_sel = 1'b0;
      #1 chk({tag, "_lo"}, 64'(hilo_out), 64'(e[W-1:0]));
      mf_sel = 1'b1;
      #1 chk({tag, "_hi"}, 64'(hilo_out), 64'(e[2*W-1:W]));
      mf_sel = 1'b0;
    end
  endtask

  // Wait (bounded) for done, counting busy cycles and checking stall each cycle.
  task automatic wait_done(input string tag, input int mf_at, input logic exp_start_stall,
                           output int busy_cnt, output logic got);
    busy_cnt = 0;
    got      = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      if (mf_at != 0 && c >= mf_at) begin
        mf_req = 1'b1;
        mf_sel = 1'b1;
      end
      #1 chk({tag, "_stall"}, 64'(stall), 64'(busy & (mf_req | exp_start_stall)));
      if (busy) busy_cnt++;
      if (done) got = 1'b1;
      else tick();
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
  endtask

  task automatic do_mult(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int mf_at);
    int   bc;
    logic got;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    sb_q.push_back(64'(a) * 64'(b));
    tick();
    start = 1'b0;
    wait_done(tag, mf_at, 1'b0, bc, got);
    chk({tag, "_busy_cycles"}, 64'(bc), 64'd32);
    check_result(tag);
    mf_req = 1'b0;
    tick();
    chk({tag, "_done_drop"}, 64'(done), 64'd0);
  endtask

  initial begin
    int   bc;
    logic got;
    logic seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0; mf_req = 1'b0; mf_sel = 1'b0;
    op_a = '0; op_b = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_lo", 64'(hilo_out), 64'd0);
    mf_sel = 1'b1;
    #1 chk("rst_hi", 64'(hilo_out), 64'd0);
    mf_sel = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    do_mult("m3x5", 32'd3, 32'd5, 0);
    do_mult("mffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_mult("m8x2_mf", 32'h8000_0000, 32'd2, 2);

    // Flush mid-run: LO/HI must keep the 7*6 result and done must never pulse.
    do_mult("m7x6", 32'd7, 32'd6, 0);
    op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    seen = 1'b0;
    repeat (35) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("flush_no_done", 64'(seen), 64'd0);
    mf_sel = 1'b0;
    #1 chk("flush_lo", 64'(hilo_out), 64'd42);
    mf_sel = 1'b1;
    #1 chk("flush_hi", 64'(hilo_out), 64'd0);
    mf_sel = 1'b0;
    tick();

    // Asynchronous reset mid-multiply.
    op_a = 32'h1234; op_b = 32'h10; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    mf_req = 1'b1;
    #1 chk("arst_pre_stall", 64'(stall), 64'd1);
    rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_lo", 64'(hilo_out), 64'd0);
    mf_req = 1'b0;
    mf_sel = 1'b1;
    #1 chk("arst_hi", 64'(hilo_out), 64'd0);
    mf_sel = 1'b0;
    rst = 1'b1;
    tick();
    do_mult("m2x2", 32'd2, 32'd2, 0);

    // Back-to-back MULTU with start held through the first operation.
    op_a = 32'd2; op_b = 32'd3; start = 1'b1;
    sb_q.push_back(64'd2 * 64'd3);
    tick();
    op_a = 32'd4; op_b = 32'd5;
    sb_q.push_back(64'd4 * 64'd5);
    wait_done("b2b1", 0, 1'b1, bc, got);
    chk("b2b1_busy_cycles", 64'(bc), 64'd32);
    chk("b2b1_done_stall", 64'(stall), 64'd0);
    check_result("b2b1");
    tick();
    start = 1'b0;
    #1;
    chk("b2b2_accept_busy", 64'(busy), 64'd1);
    chk("b2b2_accept_done", 64'(done), 64'd0);
    tick();
    wait_done("b2b2", 0, 1'b0, bc, got);
    chk("b2b2_busy_cycles", 64'(bc), 64'd31);
    check_result("b2b2");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multu_hilo_unit.md
Name: multu_hilo_unit

Overview:
- Sequential unsigned multiplier with the HI/LO register pair for the mips_pipeline EX stage.
- Consumes MULTU operands from the EX stage and performs a radix-2 shift-add over WIDTH cycles.
- Supplies HI/LO read data to MFHI/MFLO.
- Raises a stall to the hazard logic whenever the pipeline needs a result or the unit before it is ready.

Parameters:
- WIDTH, 32: operand width. HI and LO are each WIDTH bits wide.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  EX stage holds a MULTU this cycle
- op_a  input  WIDTH  multiplicand (rs value)
- op_b  input  WIDTH  multiplier (rt value)
- flush  input  1  abort any in-flight multiply (branch/jump squash)
- mf_req  input  1  EX stage holds an MFHI/MFLO this cycle
- mf_sel  input  1  0 = LO, 1 = HI
- hilo_out  output  WIDTH  mf_sel ? HI : LO, combinational
- busy  output  1  multiply in progress
- done  output  1  one-cycle pulse when HI/LO were just written
- stall  output  1  freeze IF/ID/EX this cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE; HI, LO, accumulator and counter cleared to 0.
  - busy = 0, done = 0, stall = 0.
  - Reset asserted mid-operation abandons the multiply; HI/LO read 0 afterwards.
- States: IDLE and RUN.
- IDLE:
  - On a rising edge with start=1 and flush=0: latch op_a into the multiplicand and op_b into the multiplier, clear the 2*WIDTH accumulator, set counter = 0, go to RUN.
  - start=1 together with flush=1 is ignored.
- RUN, each edge:
  - If multiplier bit[0]=1, add the multiplicand into the upper WIDTH+1 bits of the accumulator (carry kept).
  - Shift the {carry, accumulator} right by 1, shift the multiplier right by 1, increment the counter.
  - On the edge where counter == WIDTH-1: write HI = acc[2W-1:W] and LO = acc[W-1:0] from the post-step value, go to IDLE, set done = 1 for the next cycle.
- Latency: busy is high for exactly WIDTH cycles, starting the cycle after the start edge. done is high in cycle WIDTH+1 relative to the start edge, and HI/LO are valid from that cycle.
- done is registered and deasserts after one cycle.
- busy = (state == RUN).
- stall = busy & (mf_req | start), combinational.
  - A second MULTU, or an MFHI/MFLO, issued while busy is held in EX until the cycle busy falls.
  - On the final RUN cycle stall is still 1. In the next cycle (done=1) stall = 0, and hilo_out already shows the new value.
- start while busy is never accepted as a new operation; the held instruction is accepted on the first IDLE cycle.
- flush:
  - flush=1 on an edge in RUN returns to IDLE with no HI/LO write and no done pulse.
  - flush is ignored in IDLE except that it blocks start.
- HI/LO change only on completion or reset. hilo_out in IDLE always reflects the last completed MULTU.
- No signed mode; operands are treated as unsigned WIDTH-bit values.

Test Plan:
- Reset release, then op_a=3, op_b=5, start for 1 cycle -> busy high for 32 cycles; done pulses at cycle 33 with HI=0, LO=15; no stall while mf_req=0.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 (checks the carry into bit 2W).
- op_a=0x80000000, op_b=2 -> HI=1, LO=0. Raise mf_req with mf_sel=1 two cycles after start -> stall=1 until busy falls; in the done cycle stall=0 and hilo_out=1.
- Complete 7*6 (LO=42), then start 9*9 and assert flush at cycle 10 -> busy falls after that edge, no done pulse, LO still 42, HI still 0.
- Start 0x1234*0x10, drop rst at cycle 5 -> busy, done and stall go to 0 immediately without a clock edge; HI=LO=0. After release, a new 2*2 completes normally with LO=4.
- Start held high while busy (back-to-back MULTU 2*3 then 4*5) -> stall=1 during the first op; the second op is accepted in the done cycle of the first; final LO=20, with LO=6 visible in between.
